// File: rtl/link_rx_sync_pkg.sv
// Shared types and default parameters for the inter-board link receive stage.
package link_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RISE_CHK = 2'd1,
    FLIGHT   = 2'd2,
    FALL_CHK = 2'd3
  } link_state_t;

  localparam int LINK_SYNC_STAGES   = 2;
  localparam int LINK_STABLE_CYCLES = 16;
  localparam int LINK_MIN_PULSE     = 8;
  localparam int LINK_MAX_FLIGHT    = 600000;

endpackage

// File: rtl/link_rx_sync_if.sv
// Partner-board link signals: raw asynchronous inputs plus the cleaned-up outputs.
interface link_rx_sync_if;
  import link_pkg::*;

  logic        in_player1_ready;
  logic        in_player2_ready;
  logic [3:0]  in_power;
  logic        in_throw_flag;

  logic        player1_ready;
  logic        player2_ready;
  logic [3:0]  remote_power;
  logic [3:0]  throw_power;
  logic        remote_throw;
  logic        throw_start;
  logic        throw_end;
  logic        link_error;
  link_state_t dbg_state;

  modport master (
    output in_player1_ready, in_player2_ready, in_power, in_throw_flag,
    input  player1_ready, player2_ready, remote_power, throw_power,
    input  remote_throw, throw_start, throw_end, link_error, dbg_state
  );

  modport slave (
    input  in_player1_ready, in_player2_ready, in_power, in_throw_flag,
    output player1_ready, player2_ready, remote_power, throw_power,
    output remote_throw, throw_start, throw_end, link_error, dbg_state
  );

endinterface

// File: rtl/link_rx_sync_sync_stable.sv
// N-bit synchroniser followed by a stability filter: the output only follows the synced
// bus once it has held one value for STABLE_CYCLES consecutive cycles.
module sync_stable #(
  parameter int WIDTH         = 1,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  synced;

  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  end

  assign synced = sync_q[SYNC_STAGES-1];

  generate
    if (STABLE_CYCLES <= 1) begin : g_bypass
      // A single stable cycle adds nothing beyond the synchroniser itself.
      assign q_o = synced;
    end else begin : g_filter
      localparam int CW = $clog2(STABLE_CYCLES + 1);
      localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);

      logic [WIDTH-1:0] prev_q;
      logic [CW-1:0]    cnt_q, cnt_d;
      logic [WIDTH-1:0] out_q, out_d;

      always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        if (synced != prev_q) begin
          cnt_d = '0;
        end else if (cnt_q != STABLE_MAX) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == STABLE_MAX) out_d = synced;
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          prev_q <= '0;
          cnt_q  <= '0;
          out_q  <= '0;
        end else begin
          prev_q <= synced;
          cnt_q  <= cnt_d;
          out_q  <= out_d;
        end
      end

      assign q_o = out_q;
    end
  endgenerate

endmodule

// File: rtl/link_rx_sync.sv
// Receive stage for the inter-board link: synchronises ready lines and power bus, and
// turns the raw throw flag into a filtered level with start/end pulses and a flight timeout.
module link_rx_sync
  import link_pkg::*;
#(
  parameter int SYNC_STAGES   = LINK_SYNC_STAGES,
  parameter int STABLE_CYCLES = LINK_STABLE_CYCLES,
  parameter int MIN_PULSE     = LINK_MIN_PULSE,
  parameter int MAX_FLIGHT    = LINK_MAX_FLIGHT
) (
  input  logic           clk60MHz,
  input  logic           rst,
  link_rx_sync_if.slave  link
);

  localparam int PW = $clog2(MIN_PULSE + 1);
  localparam int FW = $clog2(MAX_FLIGHT + 1);
  localparam logic [PW-1:0] PMAX = PW'(MIN_PULSE);
  localparam logic [FW-1:0] FMAX = FW'(MAX_FLIGHT);

  logic [1:0] ready_sync;
  logic [3:0] power_q;
  logic       flag_sync;

  sync_stable #(.WIDTH(2), .SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(1)) u_ready (
    .clk_i (clk60MHz),
    .rst_i (rst),
    .d_i   ({link.in_player2_ready, link.in_player1_ready}),
    .q_o   (ready_sync)
  );

  sync_stable #(.WIDTH(4), .SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES)) u_power (
    .clk_i (clk60MHz),
    .rst_i (rst),
    .d_i   (link.in_power),
    .q_o   (power_q)
  );

  sync_stable #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(1)) u_flag (
    .clk_i (clk60MHz),
    .rst_i (rst),
    .d_i   (link.in_throw_flag),
    .q_o   (flag_sync)
  );

  link_state_t   state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [FW-1:0] fcnt_q, fcnt_d, fcnt_step;
  logic          start_q, start_d;
  logic          end_q, end_d;
  logic          rthrow_q, rthrow_d;
  logic          err_q, err_d;
  logic [3:0]    tpow_q, tpow_d;

  // All outputs are computed here as next-state values and registered below, so the
  // level and its pulses change on the same edge as the state.
  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    fcnt_d    = fcnt_q;
    start_d   = 1'b0;
    end_d     = 1'b0;
    err_d     = err_q;
    tpow_d    = tpow_q;
    fcnt_step = (fcnt_q == FMAX) ? fcnt_q : fcnt_q + FW'(1);

    unique case (state_q)
      IDLE: begin
        if (flag_sync) begin
          if (MIN_PULSE == 1) start_d = 1'b1;
          else begin
            state_d = RISE_CHK;
            pcnt_d  = PW'(1);
          end
        end
      end
      RISE_CHK: begin
        if (flag_sync) begin
          pcnt_d = pcnt_q + PW'(1);
          if (pcnt_d == PMAX) start_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      FLIGHT: begin
        fcnt_d = fcnt_step;
        if (!flag_sync) begin
          if (MIN_PULSE == 1) end_d = 1'b1;
          else begin
            state_d = FALL_CHK;
            pcnt_d  = PW'(1);
          end
        end
      end
      FALL_CHK: begin
        fcnt_d = fcnt_step;
        if (!flag_sync) begin
          pcnt_d = pcnt_q + PW'(1);
          if (pcnt_d == PMAX) end_d = 1'b1;
        end else begin
          state_d = FLIGHT;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_d) begin
      state_d = FLIGHT;
      fcnt_d  = '0;
      tpow_d  = power_q;
    end
    if (end_d) state_d = IDLE;
    if (fcnt_d == FMAX) err_d = 1'b1;
    rthrow_d = (state_d == FLIGHT) || (state_d == FALL_CHK);
  end

  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      state_q  <= IDLE;
      pcnt_q   <= '0;
      fcnt_q   <= '0;
      start_q  <= 1'b0;
      end_q    <= 1'b0;
      rthrow_q <= 1'b0;
      err_q    <= 1'b0;
      tpow_q   <= '0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      fcnt_q   <= fcnt_d;
      start_q  <= start_d;
      end_q    <= end_d;
      rthrow_q <= rthrow_d;
      err_q    <= err_d;
      tpow_q   <= tpow_d;
    end
  end

  assign link.player1_ready = ready_sync[0];
  assign link.player2_ready = ready_sync[1];
  assign link.remote_power  = power_q;
  assign link.throw_power   = tpow_q;
  assign link.remote_throw  = rthrow_q;
  assign link.throw_start   = start_q;
  assign link.throw_end     = end_q;
  assign link.link_error    = err_q;
  assign link.dbg_state     = state_q;

endmodule
